// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared size encodings, FSM states and legality check for lsu_ctrl
// Rev 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Reserved size is reported through the same path as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : lane enables, store-data replication, load lane select/extend
// Rev 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_lane_en,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rword >> {i_off, 3'b000};

    always_comb begin
        o_lane_en   = 4'b0000;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rword;
        case (i_size)
            SZ_B: begin
                o_lane_en   = 4'b0001 << i_off;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_H: begin
                o_lane_en   = 4'b0011 << i_off;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_W: begin
                o_lane_en   = 4'b1111;
            end
            default: begin
                o_lane_en   = 4'b0000;
                o_rdata_ext = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : load/store controller driving port A of the data memory
// Rev 1.0
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_signed,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic [AW-3:0] o_mem_addr,
    output logic [DW-1:0] o_mem_din,
    output logic          o_mem_we,
    output logic [3:0]    o_mem_en,
    input  logic [DW-1:0] i_mem_dout
);

    lsu_state_e    r_state;
    lsu_state_e    w_state_nxt;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [1:0]    r_off;
    logic          r_err;
    logic [DW-1:0] r_rsp_rdata;
    logic [AW-3:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_we;
    logic [3:0]    r_mem_en;

    logic          w_accept;
    logic          w_illegal;
    logic [1:0]    w_al_size;
    logic [1:0]    w_al_off;
    logic [3:0]    w_lane_en;
    logic [DW-1:0] w_wdata_rep;
    logic [DW-1:0] w_rdata_ext;

    assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
    assign w_illegal = is_misaligned(i_req_size, i_req_addr[1:0]);

    // Shared aligner: live request fields while IDLE, latched fields during WAIT.
    assign w_al_size = (r_state == ST_IDLE) ? i_req_size      : r_size;
    assign w_al_off  = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_off;

    lsu_align u_align (
        .i_size      (w_al_size),
        .i_off       (w_al_off),
        .i_signed    (r_signed),
        .i_wdata     (i_req_wdata),
        .i_rword     (i_mem_dout),
        .o_lane_en   (w_lane_en),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = w_illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_signed    <= 1'b0;
            r_off       <= 2'd0;
            r_err       <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_en    <= 4'b0000;
        end else begin
            // Strobes live for exactly the ISSUE cycle.
            r_mem_we <= 1'b0;
            r_mem_en <= 4'b0000;
            if (w_accept) begin
                r_we        <= i_req_we;
                r_size      <= i_req_size;
                r_signed    <= i_req_signed;
                r_off       <= i_req_addr[1:0];
                r_err       <= w_illegal;
                r_rsp_rdata <= '0;
                if (!w_illegal) begin
                    r_mem_addr <= i_req_addr[AW-1:2];
                    r_mem_we   <= i_req_we;
                    r_mem_en   <= i_req_we ? w_lane_en : 4'b1111;
                    if (i_req_we) begin
                        r_mem_din <= w_wdata_rep;
                    end
                end
            end
            if (r_state == ST_WAIT) begin
                r_rsp_rdata <= w_rdata_ext;
            end
        end
    end

    always_comb begin
        o_req_ready = (r_state == ST_IDLE);
        o_rsp_valid = (r_state == ST_RESP);
        o_rsp_rdata = r_rsp_rdata;
        o_rsp_err   = r_err;
        o_mem_addr  = r_mem_addr;
        o_mem_din   = r_mem_din;
        o_mem_we    = r_mem_we;
        o_mem_en    = r_mem_en;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting directly upstream of the dual-port data memory's port A. It accepts byte/halfword/word load and store requests from the core over a valid/ready handshake. It converts byte addresses into a word address plus per-byte lane enables, and steers and replicates store data into the correct lanes. It waits out the memory's one-cycle registered read, then returns sign- or zero-extended load data, or an error for misaligned or reserved-size accesses, over a second valid/ready handshake.

## Interface
Parameters:
- AW, 16, request byte-address width; memory word address is AW-2 = 14 bits
- DW, 32, data width; fixed at 32, four byte lanes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request
- mem_addr  out  14  word address = req_addr[15:2]
- mem_din  out  32  lane-replicated store data
- mem_we  out  1  write strobe
- mem_en  out  4  per-byte enables; nonzero means access
- mem_dout  in  32  read data, valid the cycle after the read strobe

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch the request.
  - Legal request: go to ISSUE.
  - Illegal request: go to RESP with rsp_err = 1. No memory strobe is issued.
- Legality, with off = req_addr[1:0]:
  - byte: always legal
  - half: off ∈ {0, 2}
  - word: off = 0
  - size 11: always illegal
- ISSUE: mem_* outputs driven from registers for exactly one cycle.
  - Store: mem_we = 1; mem_en = 1<<off for byte, 0011<<off for half, 1111 for word.
  - Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
  - Load: mem_we = 0, mem_en = 1111.
  - Next state: store → RESP; load → WAIT.
- WAIT: select the lane from mem_dout at byte offset off, extend per size and req_signed, and register the result into rsp_rdata. Go to RESP.
- RESP: rsp_valid = 1, with outputs stable until rsp_valid && rsp_ready, then return to IDLE. There is no back-to-back acceptance; each transaction returns through IDLE.
- Outside ISSUE: mem_en = 0 and mem_we = 0. mem_addr and mem_din hold their last values.
- Arithmetic: sign extension replicates bit 7 (byte) or bit 15 (half) of the selected lane. Stores ignore req_signed, and their rsp_rdata = 0.

## Timing
- Acceptance edge E0 (req_valid && req_ready sampled high).
- Store: strobes are active in cycle E0→E1 and the memory writes at E1. rsp_valid rises after E1, giving a 1-cycle latency.
- Load: strobes are active in cycle E0→E1 and mem_dout is valid in E1→E2. rsp_valid rises after E2, giving a 2-cycle latency.
- Error: rsp_valid rises after E0. No strobe is ever asserted.
- rsp_ready low: the block stays in RESP indefinitely and req_ready stays 0.
- rsp_ready high on the first RESP cycle: back to IDLE at the next edge. Minimum period is 3 cycles per store and 4 per load.
- Reset values: all outputs 0 except req_ready, which is 1 (state IDLE).
- Reset mid-operation: asynchronous return to IDLE, and mem_en/mem_we drop immediately.
  - A store interrupted in ISSUE is not guaranteed to commit.
  - An in-flight response is discarded.
- The address wrap-around is natural: word address 0x3FFF is legal, with no carry into higher bits.

## Structure
- lsu_pkg holds:
  - size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_RSV = 2'b11
  - the FSM state enum
  - the misalignment-check function
- Sub-module lsu_align is purely combinational. It does lane-enable generation, store-data replication, and load lane-select plus extension. lsu_ctrl instantiates it for both directions.

## Test plan
- Store word 0xDEADBEEF @0x0010 → mem_addr = 0x0004, mem_en = 1111, mem_we = 1 for 1 cycle. rsp_valid after 1 cycle, rsp_err = 0.
- Store byte 0xA5 @0x0013 → mem_en = 1000, mem_din = 0xA5A5A5A5. Then a word load @0x0010 returns 0xA5ADBEEF.
- Signed half load @0x0012 with memory word 0x80017FFF → rsp_rdata = 0xFFFF8001. The unsigned load gives 0x00008001. The signed half load @0x0010 gives 0x00007FFF. rsp_valid 2 cycles after acceptance.
- Word load @0x0011 and size 11 @0x0000 → rsp_err = 1, rsp_rdata = 0, mem_en never nonzero, rsp_valid 1 cycle after acceptance.
- Hold rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready = 0, no new strobes. Release → IDLE next cycle.
- Assert rst_n low during ISSUE of a store → mem_en/mem_we go to 0 without waiting for clk. Outputs take their reset values and req_ready = 1 after release.
